byte_regfile: RTL

Parametrised byte-serial register file with a valid/ready command handshake and fixed-length byte bursts. It is the generalised successor to the team's 4×32-bit byte-serial register block: register count, register width and byte width are configurable, the handshake is a clean single-phase accept, and read data carries an explicit valid strobe. It sits on the byte-wide control port between the host interface and the configuration/status registers of the datapath.

---
 rtl/byte_regfile_pkg.sv | 22 ++
 rtl/byte_regfile_ctrl.sv | 132 +++++++++++++
 rtl/byte_regfile.sv | 134 +++++++++++++
 3 files changed

// File: rtl/byte_regfile_pkg.sv
// byte_regfile_pkg
// Shared types for the byte-serial register file: controller state encoding
// and the command operation type decoded from the wr_n strobe.
package byte_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  // wr_n low selects a write burst, high a read burst.
  function automatic op_t decode_op(input logic wr_n);
    return wr_n ? OP_RD : OP_WR;
  endfunction

endpackage

// File: rtl/byte_regfile_ctrl.sv
// byte_regfile_ctrl
// Burst controller for byte_regfile: accepts a command when valid_i && ready_o,
// latches the register index, sequences the beat counter and produces the
// per-cycle storage strobes.
//   clk, rst_n         clock / async active-low reset
//   valid_i, wr_n      command request and direction (sampled at accept)
//   addr_i             register index (sampled at accept)
//   ready_o            registered idle indication
//   wr_en, wr_addr,    byte write strobe, target register and byte lane for
//   wr_beat              the current cycle (accept cycle carries beat 0)
//   rd_en, rd_addr,    read strobe and byte lane to be loaded into the
//   rd_beat              registered read output at the coming edge
module byte_regfile_ctrl
  import byte_regfile_pkg::*;
#(
  parameter int REG_BYTES = 4,
  parameter int ADDR_W    = 3,
  parameter int BEAT_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              ready_o,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BEAT_W-1:0] wr_beat,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [BEAT_W-1:0] rd_beat
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REG_BYTES - 1);

  state_t            state_r;
  logic [BEAT_W-1:0] beat_r;
  logic [ADDR_W-1:0] addr_r;
  logic              ready_r;
  logic              accept_s;

  assign accept_s = valid_i && ready_r;
  assign ready_o  = ready_r;

  // Storage strobes: the accept cycle uses the live address; bursts use the latch.
  // Reads are loaded one beat ahead because data_o is registered.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr_r;
    wr_beat = beat_r;
    rd_en   = 1'b0;
    rd_addr = addr_r;
    rd_beat = beat_r + BEAT_W'(1);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (decode_op(wr_n) == OP_WR) begin
            wr_en   = 1'b1;
            wr_addr = addr_i;
            wr_beat = {BEAT_W{1'b0}};
          end else begin
            rd_en   = 1'b1;
            rd_addr = addr_i;
            rd_beat = {BEAT_W{1'b0}};
          end
        end else begin
          wr_en = 1'b0;
          rd_en = 1'b0;
        end
      end
      WR_BURST: begin
        wr_en = 1'b1;
      end
      RD_BURST: begin
        if (beat_r != LAST_BEAT) begin
          rd_en = 1'b1;
        end else begin
          rd_en = 1'b0;
        end
      end
      default: begin
        wr_en = 1'b0;
        rd_en = 1'b0;
      end
    endcase
  end

  // FSM, beat counter, address latch and registered ready.
  // A write's beat 0 happens in the accept cycle, so the write burst state
  // starts at beat 1; a read burst starts at beat 0 one cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      beat_r  <= {BEAT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            addr_r  <= addr_i;
            ready_r <= 1'b0;
            if (decode_op(wr_n) == OP_WR) begin
              state_r <= WR_BURST;
              beat_r  <= BEAT_W'(1);
            end else begin
              state_r <= RD_BURST;
              beat_r  <= {BEAT_W{1'b0}};
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        WR_BURST, RD_BURST: begin
          if (beat_r == LAST_BEAT) begin
            state_r <= IDLE;
            beat_r  <= {BEAT_W{1'b0}};
            ready_r <= 1'b1;
          end else begin
            beat_r  <= beat_r + BEAT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= {BEAT_W{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/byte_regfile.sv
// byte_regfile
// Parametrised byte-serial register file. A command is accepted when
// valid_i && ready_o; a burst then moves REG_BYTES bytes little-endian
// (beat k is bits [k*DATA_W +: DATA_W]) into or out of one register.
//   clk, rst_n   clock / async active-low reset (clears all registers)
//   valid_i      command request
//   wr_n         0 = write burst, 1 = read burst
//   addr_i       register index
//   data_i       write byte (beat 0 in the accept cycle)
//   ready_o      idle, able to accept (registered)
//   data_o       read byte, zero when rvalid_o is low (registered)
//   rvalid_o     data_o carries a read byte (registered)
// Build option BYTE_REGFILE_WR_CNT_EN: the last register becomes a read-only
// count of completed write bursts to the other registers.
module byte_regfile
  import byte_regfile_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int REG_BYTES = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic              wr_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              rvalid_o
);

  localparam int BEAT_W = $clog2(REG_BYTES);
  localparam int REG_W  = REG_BYTES * DATA_W;

  logic [REG_W-1:0]  regs_r [NUM_REGS];
  logic [DATA_W-1:0] data_r;
  logic              rvalid_r;

  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [BEAT_W-1:0] wr_beat_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [BEAT_W-1:0] rd_beat_s;
  logic [DATA_W-1:0] rd_byte_s;

  byte_regfile_ctrl #(
    .REG_BYTES (REG_BYTES),
    .ADDR_W    (ADDR_W),
    .BEAT_W    (BEAT_W)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .wr_n    (wr_n),
    .addr_i  (addr_i),
    .ready_o (ready_o),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_beat (wr_beat_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_beat (rd_beat_s)
  );

`ifdef BYTE_REGFILE_WR_CNT_EN
  localparam logic [ADDR_W-1:0] CNT_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(REG_BYTES - 1);

  logic wr_last_s;
  logic wr_store_s;

  // Final beat of a write burst; REG_BYTES >= 2 keeps this out of the accept cycle.
  assign wr_last_s  = wr_en_s && (wr_beat_s == LAST_BEAT);
  assign wr_store_s = wr_addr_s != CNT_IDX;

  // Storage: byte-lane writes to ordinary registers, counter bumped on
  // completion of a counted burst; the counter register itself is read-only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {REG_W{1'b0}};
      end
    end else begin
      if (wr_en_s && wr_store_s) begin
        regs_r[wr_addr_s][wr_beat_s*DATA_W +: DATA_W] <= data_i;
      end
      if (wr_last_s && wr_store_s) begin
        regs_r[CNT_IDX] <= regs_r[CNT_IDX] + REG_W'(1);
      end
    end
  end
`else
  // Storage: byte-lane writes into any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {REG_W{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        regs_r[wr_addr_s][wr_beat_s*DATA_W +: DATA_W] <= data_i;
      end
    end
  end
`endif

  // Read mux: selected byte lane of the selected register.
  always_comb begin
    rd_byte_s = regs_r[rd_addr_s][rd_beat_s*DATA_W +: DATA_W];
  end

  // Registered read output; data is forced to zero whenever no byte is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= {DATA_W{1'b0}};
      rvalid_r <= 1'b0;
    end else begin
      if (rd_en_s) begin
        data_r   <= rd_byte_s;
        rvalid_r <= 1'b1;
      end else begin
        data_r   <= {DATA_W{1'b0}};
        rvalid_r <= 1'b0;
      end
    end
  end

  assign data_o   = data_r;
  assign rvalid_o = rvalid_r;

endmodule
